// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register file widths and defaults
// Purpose: width constants and helpers shared by the register file and its
// write arbiter.
// Ports: none (package).
package regfile_pkg;

  localparam int DEFAULT_REGISTER_NUM = 32;
  localparam int DEFAULT_MEMORY_WIDTH = 32;
  localparam int DEFAULT_REQUESTERS   = 2;

  // Index width that stays at least one bit wide for degenerate counts.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int AW = idx_width(DEFAULT_REGISTER_NUM);
  localparam int IW = idx_width(DEFAULT_REQUESTERS);

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
// Purpose: grants the first requester at or above ptr (with wrap) whose req
// bit is set, while enable is high.
// Ports:
//   req     - request vector, one bit per requester
//   ptr     - index holding highest priority this cycle
//   enable  - grants are suppressed when low
//   gnt     - one-hot grant (zero when no grant)
//   gnt_idx - encoded index of the granted requester (0 when none)
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]              req,
  input  logic [idx_width(N)-1:0]   ptr,
  input  logic                      enable,
  output logic [N-1:0]              gnt,
  output logic [idx_width(N)-1:0]   gnt_idx
);

  localparam int IDX_W = idx_width(N);

  logic found;

  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    // Scan offsets 0..N-1 from ptr; the first hit wins.
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (enable && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = IDX_W'(idx);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter for the register file write port
// Purpose: shares the single register file write port among several
// writeback sources; drives a registered write strobe/address/data. Writes
// to register 0 are accepted but never strobed into the file.
// Ports:
//   clk, reset          - clock, asynchronous active-low reset
//   hold                - suppresses grants this cycle
//   req_valid/addr/data - per-requester write requests (packed slices)
//   req_ready           - one-hot grant back to the requesters
//   writeEnable/Addr/Data - registered register file write port
//   grant_id            - index of the last granted requester
//   busy                - some valid requester was not granted this cycle
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int memory_width   = DEFAULT_MEMORY_WIDTH,
  parameter int register_num   = DEFAULT_REGISTER_NUM,
  parameter int num_requesters = DEFAULT_REQUESTERS
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          hold,
  input  logic [num_requesters-1:0]                     req_valid,
  input  logic [num_requesters*idx_width(register_num)-1:0] req_addr,
  input  logic [num_requesters*memory_width-1:0]        req_data,
  output logic [num_requesters-1:0]                     req_ready,
  output logic                                          writeEnable,
  output logic [idx_width(register_num)-1:0]            writeAddr,
  output logic [memory_width-1:0]                       writeData,
  output logic [idx_width(num_requesters)-1:0]          grant_id,
  output logic                                          busy
);

  localparam int ADDR_W = idx_width(register_num);
  localparam int IDX_W  = idx_width(num_requesters);

  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic                    write_enable_q, write_enable_d;
  logic [ADDR_W-1:0]       write_addr_q, write_addr_d;
  logic [memory_width-1:0] write_data_q, write_data_d;
  logic [IDX_W-1:0]        grant_id_q, grant_id_d;

  logic [num_requesters-1:0] gnt;
  logic [IDX_W-1:0]          gnt_idx;
  logic                      transfer;
  logic [ADDR_W-1:0]         sel_addr;
  logic [memory_width-1:0]   sel_data;

  rr_arbiter #(
    .N(num_requesters)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (ptr_q),
    .enable  (!hold),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // The arbiter only grants valid requesters, so any grant is a transfer.
  assign transfer = |gnt;
  assign sel_addr = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign sel_data = req_data[int'(gnt_idx)*memory_width +: memory_width];

  always_comb begin
    ptr_d          = ptr_q;
    write_enable_d = 1'b0;
    write_addr_d   = write_addr_q;
    write_data_d   = write_data_q;
    grant_id_d     = grant_id_q;
    if (transfer) begin
      ptr_d          = IDX_W'((int'(gnt_idx) + 1) % num_requesters);
      // Register 0 is hard-wired: the write is consumed but not strobed.
      write_enable_d = (sel_addr != '0);
      write_addr_d   = sel_addr;
      write_data_d   = sel_data;
      grant_id_d     = gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q          <= '0;
      write_enable_q <= 1'b0;
      write_addr_q   <= '0;
      write_data_q   <= '0;
      grant_id_q     <= '0;
    end else begin
      ptr_q          <= ptr_d;
      write_enable_q <= write_enable_d;
      write_addr_q   <= write_addr_d;
      write_data_q   <= write_data_d;
      grant_id_q     <= grant_id_d;
    end
  end

  assign req_ready   = gnt;
  assign busy        = |(req_valid & ~gnt);
  assign writeEnable = write_enable_q;
  assign writeAddr   = write_addr_q;
  assign writeData   = write_data_q;
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  localparam int N  = 2;
  localparam int MW = DEFAULT_MEMORY_WIDTH;

  logic              clk = 1'b0;
  logic              reset;
  logic              hold;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*MW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              writeEnable;
  logic [AW-1:0]     writeAddr;
  logic [MW-1:0]     writeData;
  logic [IW-1:0]     grant_id;
  logic              busy;

  regfile_write_arbiter #(
    .memory_width(MW), .register_num(DEFAULT_REGISTER_NUM), .num_requesters(N)
  ) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .writeEnable(writeEnable), .writeAddr(writeAddr),
    .writeData(writeData), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // Requester model: each source holds its request until granted.
  logic          r_valid [N];
  logic [AW-1:0] r_addr  [N];
  logic [MW-1:0] r_data  [N];
  int            m_ptr = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [MW-1:0] d;
    int            id;
  } wr_t;
  wr_t exp_q[$];
  logic [MW-1:0] file_m [32];

  function automatic int model_grant();
    if (hold) return -1;
    for (int k = 0; k < N; k++)
      if (r_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = r_valid[i];
      req_addr[i*AW +: AW]  = r_addr[i];
      req_data[i*MW +: MW]  = r_data[i];
    end
  endtask

  // Called at a falling edge: drive, check combinational outputs, let the
  // rising edge happen, retire the granted request, return at the next fall.
  task automatic step(output int g);
    logic [N-1:0] exp_ready;
    logic [N-1:0] vld;
    drive_inputs();
    #1;
    g = model_grant();
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    for (int i = 0; i < N; i++) vld[i] = r_valid[i];
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("busy", 64'(busy), 64'(|(vld & ~exp_ready)));
    if (g >= 0) begin
      if (r_addr[g] != 0) exp_q.push_back('{a: r_addr[g], d: r_data[g], id: g});
      m_ptr = (g + 1) % N;
    end
    @(posedge clk);
    if (g >= 0) r_valid[g] = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    int g;
    for (int i = 0; i < N; i++) r_valid[i] = 1'b0;
    for (int c = 0; c < n; c++) step(g);
  endtask

  // Monitor: every strobed write must match the oldest expected write.
  always @(negedge clk) begin
    if (reset && writeEnable) begin
      chk("write_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("writeAddr", 64'(writeAddr), 64'(e.a));
        chk("writeData", 64'(writeData), 64'(e.d));
        chk("grant_id", 64'(grant_id), 64'(e.id));
        file_m[writeAddr] = writeData;
      end
    end
  end

  initial begin
    int g;
    int saved_ptr;
    for (int i = 0; i < N; i++) begin
      r_valid[i] = 1'b0; r_addr[i] = '0; r_data[i] = '0;
    end
    for (int i = 0; i < 32; i++) file_m[i] = '0;
    hold = 1'b0;
    reset = 1'b0;
    drive_inputs();
    #1;
    chk("reset_we", 64'(writeEnable), 64'd0);
    chk("reset_addr", 64'(writeAddr), 64'd0);
    chk("reset_data", 64'(writeData), 64'd0);
    chk("reset_gid", 64'(grant_id), 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    // Single requester.
    r_valid[0] = 1'b1; r_addr[0] = 5; r_data[0] = 32'hDEADBEEF;
    step(g);
    chk("single_we", 64'(writeEnable), 64'd1);
    chk("single_gid", 64'(grant_id), 64'd0);
    idle(1);

    // Round robin, both always valid.
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!r_valid[i]) begin
          r_valid[i] = 1'b1; r_addr[i] = AW'(3 + i); r_data[i] = $urandom;
        end
      end
      step(g);
      chk("rr_we_continuous", 64'(writeEnable), 64'd1);
    end
    idle(1);

    // Zero register then a normal write.
    r_valid[1] = 1'b1; r_addr[1] = 0; r_data[1] = 32'h12345678;
    step(g);
    chk("zero_gid", 64'(grant_id), 64'd1);
    chk("zero_we", 64'(writeEnable), 64'd0);
    r_valid[0] = 1'b1; r_addr[0] = 7; r_data[0] = $urandom;
    step(g);
    chk("after_zero_we", 64'(writeEnable), 64'd1);
    idle(1);

    // Hold for three cycles, then release.
    for (int i = 0; i < N; i++) begin
      r_valid[i] = 1'b1; r_addr[i] = AW'(10 + i); r_data[i] = $urandom;
    end
    saved_ptr = m_ptr;
    hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(g);
      chk("hold_we", 64'(writeEnable), 64'd0);
    end
    hold = 1'b0;
    step(g);
    chk("hold_release_grant", 64'(g), 64'(saved_ptr));
    idle(2);

    // Same-address collision starting from ptr 0.
    if (m_ptr != 0) begin
      r_valid[1] = 1'b1; r_addr[1] = 1; r_data[1] = $urandom;
      step(g);
    end
    r_valid[0] = 1'b1; r_addr[0] = 9; r_data[0] = 32'hA;
    r_valid[1] = 1'b1; r_addr[1] = 9; r_data[1] = 32'hB;
    step(g);
    step(g);
    idle(2);
    chk("collision_file", 64'(file_m[9]), 64'hB);

    // Reset while a write is pending on the output stage.
    r_valid[0] = 1'b1; r_addr[0] = 6; r_data[0] = $urandom;
    drive_inputs();
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midreset_we", 64'(writeEnable), 64'd0);
    chk("midreset_addr", 64'(writeAddr), 64'd0);
    chk("midreset_data", 64'(writeData), 64'd0);
    exp_q.delete();
    m_ptr = 0;
    r_valid[1] = 1'b1; r_addr[1] = 8; r_data[1] = $urandom;
    drive_inputs();
    @(negedge clk);
    reset = 1'b1;
    step(g);
    chk("post_reset_ptr", 64'(g), 64'd0);
    idle(2);

    // Randomized traffic.
    for (int c = 0; c < 300; c++) begin
      hold = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < N; i++) begin
        if (!r_valid[i] && $urandom_range(0, 1) == 1) begin
          r_valid[i] = 1'b1;
          r_addr[i]  = AW'($urandom_range(0, 31));
          r_data[i]  = $urandom;
        end
      end
      step(g);
    end
    hold = 1'b0;
    idle(3);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
